// File: rtl/clint_slave_pkg.sv
// Shared CLINT configuration: RTC divider ratio, register offsets and the
// helpers used for address decode and byte-granular stores.
package clint_slave_pkg;

    localparam int unsigned clk_divider_rtc = 4;

    localparam logic [15:0] clint_msip_off     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
    localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

    localparam logic [13:0] msip_word      = clint_msip_off[15:2];
    localparam logic [13:0] mtimecmp_lo_w  = clint_mtimecmp_off[15:2];
    localparam logic [13:0] mtimecmp_hi_w  = mtimecmp_lo_w + 14'd1;
    localparam logic [13:0] mtime_lo_w     = clint_mtime_off[15:2];
    localparam logic [13:0] mtime_hi_w     = mtime_lo_w + 14'd1;

    typedef enum logic [2:0] {
        reg_msip,
        reg_mtimecmp_lo,
        reg_mtimecmp_hi,
        reg_mtime_lo,
        reg_mtime_hi,
        reg_none
    } clint_reg_e;

    function automatic clint_reg_e clint_decode(input logic [13:0] word);
        case (word)
            msip_word:     return reg_msip;
            mtimecmp_lo_w: return reg_mtimecmp_lo;
            mtimecmp_hi_w: return reg_mtimecmp_hi;
            mtime_lo_w:    return reg_mtime_lo;
            mtime_hi_w:    return reg_mtime_hi;
            default:       return reg_none;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_slave_if.sv
// Native memory bus (valid/ready) between the interconnect and the CLINT.
interface clint_slave_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/clint_slave_rtc_tick.sv
// RTC tick generator: counts 0..CLK_DIVIDER per half-period and emits one
// tick per full RTC period, i.e. every 2*(CLK_DIVIDER+1) clocks.
module clint_rtc_tick #(
    parameter int unsigned CLK_DIVIDER = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int unsigned CW = (CLK_DIVIDER > 0) ? $clog2(CLK_DIVIDER + 1) : 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;

    assign wrap = (cnt == CW'(CLK_DIVIDER));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

    // The RTC edge lands where the phase closes its second half-period, which
    // places the first tick a full period after reset release.
    assign tick = wrap && phase;
endmodule

// File: rtl/clint_slave.sv
// CLINT responder: msip, mtimecmp and the 64-bit mtime behind a one-cycle
// valid/ready slave, plus the software and timer interrupt lines.
module clint_slave
    import clint_slave_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER    = clk_divider_rtc,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         clock,
    input  logic         reset,
    clint_slave_if.slave mem,
    output logic         clint_msip,
    output logic         clint_mtip,
    output logic [63:0]  clint_mtime
);
    logic        tick;
    logic        accept;
    logic        wr;
    clint_reg_e  sel;
    logic [31:0] rd_data;
    logic        msip_q, msip_nxt;
    logic [63:0] mtime_q, mtime_nxt;
    logic [63:0] mtimecmp_q, mtimecmp_nxt;
    logic        unused_bits;

    clint_rtc_tick #(.CLK_DIVIDER(CLK_DIVIDER)) u_rtc_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign accept      = mem.mem_valid && !mem.mem_ready;
    assign wr          = accept && (mem.mem_wstrb != 4'b0000);
    assign sel         = clint_decode(mem.mem_addr[15:2]);
    assign unused_bits = ^{mem.mem_instr, mem.mem_addr[31:16], mem.mem_addr[1:0]};

    always_comb begin
        rd_data = '0;
        case (sel)
            reg_msip:        rd_data = {31'd0, msip_q};
            reg_mtimecmp_lo: rd_data = mtimecmp_q[31:0];
            reg_mtimecmp_hi: rd_data = mtimecmp_q[63:32];
            reg_mtime_lo:    rd_data = mtime_q[31:0];
            reg_mtime_hi:    rd_data = mtime_q[63:32];
            default:         rd_data = '0;
        endcase
    end

    // A store to either mtime word replaces that tick's increment entirely.
    always_comb begin
        msip_nxt     = msip_q;
        mtimecmp_nxt = mtimecmp_q;
        mtime_nxt    = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr) begin
            case (sel)
                reg_msip: begin
                    if (mem.mem_wstrb[0]) msip_nxt = mem.mem_wdata[0];
                end
                reg_mtimecmp_lo: mtimecmp_nxt[31:0]  =
                    merge_bytes(mtimecmp_q[31:0], mem.mem_wdata, mem.mem_wstrb);
                reg_mtimecmp_hi: mtimecmp_nxt[63:32] =
                    merge_bytes(mtimecmp_q[63:32], mem.mem_wdata, mem.mem_wstrb);
                reg_mtime_lo: mtime_nxt =
                    {mtime_q[63:32], merge_bytes(mtime_q[31:0], mem.mem_wdata, mem.mem_wstrb)};
                reg_mtime_hi: mtime_nxt =
                    {merge_bytes(mtime_q[63:32], mem.mem_wdata, mem.mem_wstrb), mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem.mem_ready <= 1'b0;
            mem.mem_rdata <= '0;
            msip_q        <= 1'b0;
            mtime_q       <= '0;
            mtimecmp_q    <= MTIMECMP_RESET;
            clint_mtip    <= 1'b0;
        end else begin
            mem.mem_ready <= accept;
            mem.mem_rdata <= accept ? rd_data : '0;
            msip_q        <= msip_nxt;
            mtime_q       <= mtime_nxt;
            mtimecmp_q    <= mtimecmp_nxt;
            clint_mtip    <= (mtime_q >= mtimecmp_q);
        end
    end

    assign clint_msip  = msip_q;
    assign clint_mtime = mtime_q;
endmodule

// File: tb/tb_clint_slave.sv
// Self-checking bench for clint_slave: directed scenarios plus random bus
// traffic, all compared every cycle against a cycle-count based model.
module tb_clint_slave;
    import clint_slave_pkg::*;

    localparam int unsigned TICK_PERIOD = 2 * (clk_divider_rtc + 1);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        msip, mtip;
    logic [63:0] mtime;

    always #5 clock = ~clock;

    clint_slave_if mem_if ();

    clint_slave #(
        .CLK_DIVIDER    (clk_divider_rtc),
        .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem         (mem_if),
        .clint_msip  (msip),
        .clint_mtip  (mtip),
        .clint_mtime (mtime)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state after each clock edge, ticks from the cycle count.
    int unsigned cyc = 0;
    logic        m_started = 1'b0;
    logic [63:0] m_mtime, m_cmp;
    logic        m_msip, m_mtip, e_ready;
    logic [31:0] e_rdata;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [15:0] w;
        w = {a[15:2], 2'b00};
        case (w)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] put_bytes(input logic [31:0] old_w, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clock) begin : model
        logic        acc;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [63:0] next_mtime;
        if (reset) begin
            cyc       = 0;
            m_started = 1'b1;
            m_mtime   = 64'd0;
            m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip    = 1'b0;
            m_mtip    = 1'b0;
            e_ready   = 1'b0;
            e_rdata   = 32'd0;
        end else begin
            cyc++;
            a   = mem_if.mem_addr;
            d   = mem_if.mem_wdata;
            s   = mem_if.mem_wstrb;
            acc = mem_if.mem_valid && !e_ready;
            next_mtime = (cyc % TICK_PERIOD == 0) ? m_mtime + 64'd1 : m_mtime;
            m_mtip = (m_mtime >= m_cmp);
            if (acc) begin
                e_ready = 1'b1;
                e_rdata = m_read(a);
                if (s != 4'b0000) begin
                    case ({a[15:2], 2'b00})
                        16'h0000: if (s[0]) m_msip = d[0];
                        16'h4000: m_cmp[31:0]  = put_bytes(m_cmp[31:0], d, s);
                        16'h4004: m_cmp[63:32] = put_bytes(m_cmp[63:32], d, s);
                        16'hBFF8: next_mtime = {m_mtime[63:32], put_bytes(m_mtime[31:0], d, s)};
                        16'hBFFC: next_mtime = {put_bytes(m_mtime[63:32], d, s), m_mtime[31:0]};
                        default: ;
                    endcase
                end
            end else begin
                e_ready = 1'b0;
                e_rdata = 32'd0;
            end
            m_mtime = next_mtime;
        end
    end

    always @(negedge clock) begin
        if (m_started) begin
            check("cyc_mem_ready", 64'(mem_if.mem_ready), 64'(e_ready));
            check("cyc_mem_rdata", 64'(mem_if.mem_rdata), 64'(e_rdata));
            check("cyc_msip", 64'(msip), 64'(m_msip));
            check("cyc_mtip", 64'(mtip), 64'(m_mtip));
            check("cyc_mtime", mtime, m_mtime);
        end
    end

    // Called at a negedge; returns at the negedge where mem_ready is seen.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
        int n = 0;
        int exp_n;
        exp_n = e_ready ? 2 : 1;
        mem_if.mem_valid = 1'b1;
        mem_if.mem_addr  = addr;
        mem_if.mem_wdata = wdata;
        mem_if.mem_wstrb = wstrb;
        mem_if.mem_instr = 1'($urandom_range(0, 1));
        do begin
            @(negedge clock);
            n++;
        end while (!mem_if.mem_ready && n < 6);
        check("latency", 64'(n), 64'(exp_n));
        rdata = mem_if.mem_rdata;
        mem_if.mem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [15:0] offs [5];
        int n;
        offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004;
        offs[3] = 16'hBFF8; offs[4] = 16'hBFFC;

        mem_if.mem_valid = 1'b0;
        mem_if.mem_instr = 1'b0;
        mem_if.mem_addr  = '0;
        mem_if.mem_wdata = '0;
        mem_if.mem_wstrb = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        repeat (35) @(negedge clock);
        check("idle_mtime", mtime, 64'd3);
        check("idle_msip", 64'(msip), 64'd0);
        check("idle_mtip", 64'(mtip), 64'd0);
        check("idle_ready", 64'(mem_if.mem_ready), 64'd0);

        access(32'h0000_BFFC, 32'd0, 4'b0000, rd);
        check("ld_mtime_hi", 64'(rd), 64'd0);
        access(32'h0000_1234, 32'hDEAD_BEEF, 4'hF, rd);
        access(32'h0000_1234, 32'd0, 4'b0000, rd);
        check("unmapped_ld", 64'(rd), 64'd0);

        access(32'h0000_4004, 32'd0, 4'hF, rd);
        access(32'h0000_4000, 32'd5, 4'hF, rd);
        n = 0;
        while (mtime != 64'd5 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("mtime_reach5", mtime, 64'd5);
        check("mtip_lag", 64'(mtip), 64'd0);
        @(negedge clock);
        check("mtip_rise", 64'(mtip), 64'd1);
        access(32'h0000_4004, 32'd1, 4'hF, rd);
        check("mtip_hold", 64'(mtip), 64'd1);
        @(negedge clock);
        check("mtip_fall", 64'(mtip), 64'd0);

        access(32'h0000_0000, 32'hFFFF_FFFF, 4'b0001, rd);
        check("msip_set", 64'(msip), 64'd1);
        access(32'h0000_0000, 32'd0, 4'b0000, rd);
        check("msip_ld", 64'(rd), 64'd1);
        access(32'h0000_0000, 32'd0, 4'b0010, rd);
        check("msip_byte1", 64'(msip), 64'd1);

        access(32'h0000_BFFC, 32'd0, 4'hF, rd);
        @(negedge clock);
        n = 0;
        while ((cyc % TICK_PERIOD) != (TICK_PERIOD - 1) && n < 20) begin
            @(negedge clock);
            n++;
        end
        access(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
        check("mtime_tick_write", mtime, 64'h0000_0000_FFFF_FFFF);
        repeat (TICK_PERIOD) @(negedge clock);
        check("mtime_carry", mtime, 64'h0000_0001_0000_0000);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] off;
            logic [3:0]  strb;
            int          sel;
            sel  = $urandom_range(0, 5);
            off  = (sel == 5) ? 16'($urandom) : offs[sel];
            strb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            access({16'($urandom), off[15:2], 2'($urandom)}, $urandom, strb, rd);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        @(negedge clock);
        mem_if.mem_valid = 1'b1;
        mem_if.mem_addr  = 32'h0000_4000;
        mem_if.mem_wdata = 32'h1234_5678;
        mem_if.mem_wstrb = 4'hF;
        reset = 1'b1;
        @(negedge clock);
        check("rst_no_ready", 64'(mem_if.mem_ready), 64'd0);
        reset = 1'b0;
        mem_if.mem_valid = 1'b0;
        @(negedge clock);
        check("rst_no_ready2", 64'(mem_if.mem_ready), 64'd0);
        access(32'h0000_4000, 32'd0, 4'b0000, rd);
        check("cmp_lo_after_rst", 64'(rd), 64'h0000_0000_FFFF_FFFF);
        access(32'h0000_4004, 32'd0, 4'b0000, rd);
        check("cmp_hi_after_rst", 64'(rd), 64'h0000_0000_FFFF_FFFF);
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
